// File: rtl/boe_pkg.sv
// boe_pkg: shared parameters, issue FSM state encoding and result-tag codes
// for the BOE feeder (boe_feeder, boe_grp_buf).
package boe_pkg;

  localparam int MAX_NUM = 6;  // bytes per group, 1..7 (data_num is 3 bits)
  localparam int DW      = 8;  // byte width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } boe_state_e;

  // res_tag codes, aligned with BOE's result stream
  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_MAX  = 2'd1;
  localparam logic [1:0] TAG_SUM  = 2'd2;
  localparam logic [1:0] TAG_SORT = 2'd3;

  // BOE needs N+3 cycles after the last byte; the drain counter counts N+2 down to 0.
  function automatic logic [3:0] drain_len(input logic [2:0] n);
    return {1'b0, n} + 4'd2;
  endfunction

endpackage

// File: rtl/boe_grp_buf.sv
// boe_grp_buf: one group buffer of MAX_NUM x DW bytes with a fill length and
// a full flag. The host side appends bytes; the buffer closes itself on
// wr_last or when it reaches MAX_NUM bytes. clr empties it after replay.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_en, wr_data      append one byte (caller guarantees buffer not full)
//   wr_last             byte is the last of its group
//   clr                 discard contents (caller guarantees no write same cycle)
//   rd_addr, rd_data    combinational read port
//   len                 bytes currently held
//   full                group closed, waiting for / under replay
//   closing             this write closes the group
//   overflow            this write closes the group without wr_last
module boe_grp_buf #(
  parameter int MAX_NUM = boe_pkg::MAX_NUM,
  parameter int DW      = boe_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_last,
  input  logic          clr,
  input  logic [2:0]    rd_addr,
  output logic [DW-1:0] rd_data,
  output logic [2:0]    len,
  output logic          full,
  output logic          closing,
  output logic          overflow
);
  import boe_pkg::*;

  logic [DW-1:0] mem [MAX_NUM];
  logic          at_cap;

  assign at_cap   = (len == 3'(MAX_NUM - 1));
  assign closing  = wr_en & (wr_last | at_cap);
  assign overflow = wr_en & ~wr_last & at_cap;
  assign rd_data  = mem[rd_addr];

  // Storage is not reset: stale bytes are unreachable once len/full are cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[len] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      len  <= 3'd0;
      full <= 1'b0;
    end else if (wr_en) begin
      len <= len + 3'd1;
      if (wr_last || at_cap) full <= 1'b1;
    end
  end

endmodule

// File: rtl/boe_feeder.sv
// boe_feeder: collects host bytes into ping-pong group buffers and replays
// each complete group to BOE gaplessly, owning BOE's reset so every group
// starts from a clean BOE.
//
// Optional feature: define BOE_FEEDER_TAG_EN to add res_tag/res_last, which
// label BOE's result stream (max, sum, sorted values, last sorted value).
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_last   host byte stream
//   boe_rst                        registered reset to BOE
//   data_num                       group length on the first issue cycle, else 0
//   data_in                        group byte during issue cycles, else 0
//   len_err                        sticky: a group hit MAX_NUM without in_last
//   res_tag, res_last              (BOE_FEEDER_TAG_EN only) result labels
//
// Issue FSM:
//   state | meaning
//   IDLE  | boe_rst high, waiting for the read buffer to be full
//   ISSUE | streaming the group bytes to BOE, boe_rst low
//   DRAIN | BOE emits results (N+3 cycles), boe_rst low, no data
module boe_feeder #(
  parameter int MAX_NUM = boe_pkg::MAX_NUM,
  parameter int DW      = boe_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          boe_rst,
  output logic [2:0]    data_num,
  output logic [DW-1:0] data_in,
  output logic          len_err
`ifdef BOE_FEEDER_TAG_EN
  ,
  output logic [1:0]    res_tag,
  output logic [0:0]    res_last
`endif
);
  import boe_pkg::*;

  logic          wr_sel, rd_sel, rd_sel_nxt;
  logic          accept;
  logic [1:0]    wr_en, clr, full, closing, overflow;
  logic [DW-1:0] buf_data [2];
  logic [2:0]    buf_len  [2];

  logic          rd_full;
  logic [2:0]    rd_len;
  logic [DW-1:0] rd_byte;
  logic          rel_grp;

  boe_state_e    state, state_nxt;
  logic [2:0]    rd_idx, rd_idx_nxt;
  logic [3:0]    drain_cnt, drain_cnt_nxt;
  logic          boe_rst_nxt;
  logic [2:0]    data_num_nxt;
  logic [DW-1:0] data_in_nxt;

  // ---------------------------------------------------------------- host side
  assign in_ready = ~full[wr_sel];
  assign accept   = in_valid & in_ready;

  for (genvar i = 0; i < 2; i++) begin : g_buf
    assign wr_en[i] = accept & (wr_sel == 1'(i));
    assign clr[i]   = rel_grp & (rd_sel == 1'(i));

    boe_grp_buf #(.MAX_NUM(MAX_NUM), .DW(DW)) u_buf (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en[i]),
      .wr_data  (in_data),
      .wr_last  (in_last),
      .clr      (clr[i]),
      .rd_addr  (rd_idx),
      .rd_data  (buf_data[i]),
      .len      (buf_len[i]),
      .full     (full[i]),
      .closing  (closing[i]),
      .overflow (overflow[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel  <= 1'b0;
      len_err <= 1'b0;
    end else begin
      if (|closing)  wr_sel  <= ~wr_sel;
      if (|overflow) len_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- issue side
  assign rd_full = full[rd_sel];
  assign rd_len  = buf_len[rd_sel];
  assign rd_byte = buf_data[rd_sel];

  // Outputs are registered: each branch computes what BOE sees next cycle.
  always_comb begin
    state_nxt     = state;
    rd_sel_nxt    = rd_sel;
    rd_idx_nxt    = rd_idx;
    drain_cnt_nxt = drain_cnt;
    boe_rst_nxt   = 1'b0;
    data_num_nxt  = 3'd0;
    data_in_nxt   = '0;
    rel_grp       = 1'b0;
    case (state)
      ISSUE: begin
        if (rd_idx == rd_len) begin
          // Last byte is on the bus now; hand the buffer back to the host.
          rel_grp       = 1'b1;
          rd_sel_nxt    = ~rd_sel;
          rd_idx_nxt    = 3'd0;
          drain_cnt_nxt = drain_len(rd_len);
          state_nxt     = DRAIN;
        end else begin
          data_in_nxt = rd_byte;
          rd_idx_nxt  = rd_idx + 3'd1;
        end
      end
      DRAIN: begin
        if (drain_cnt == 4'd0) begin
          boe_rst_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          drain_cnt_nxt = drain_cnt - 4'd1;
        end
      end
      default: begin
        boe_rst_nxt = 1'b1;
        if (rd_full) begin
          boe_rst_nxt  = 1'b0;
          data_num_nxt = rd_len;
          data_in_nxt  = rd_byte;
          rd_idx_nxt   = 3'd1;
          state_nxt    = ISSUE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_sel    <= 1'b0;
      rd_idx    <= 3'd0;
      drain_cnt <= 4'd0;
      boe_rst   <= 1'b1;
      data_num  <= 3'd0;
      data_in   <= '0;
    end else begin
      state     <= state_nxt;
      rd_sel    <= rd_sel_nxt;
      rd_idx    <= rd_idx_nxt;
      drain_cnt <= drain_cnt_nxt;
      boe_rst   <= boe_rst_nxt;
      data_num  <= data_num_nxt;
      data_in   <= data_in_nxt;
    end
  end

`ifdef BOE_FEEDER_TAG_EN
  // Group length is latched because the buffer is cleared before DRAIN starts.
  logic [2:0] grp_len;
  logic [1:0] res_tag_nxt;
  logic       res_last_nxt;

  always_comb begin
    res_tag_nxt  = TAG_NONE;
    res_last_nxt = 1'b0;
    if (state == DRAIN) begin
      if (drain_cnt == drain_len(grp_len))              res_tag_nxt = TAG_MAX;
      else if (drain_cnt == drain_len(grp_len) - 4'd1)  res_tag_nxt = TAG_SUM;
      else if (drain_cnt != 4'd0)                       res_tag_nxt = TAG_SORT;
      res_last_nxt = (drain_cnt == 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grp_len  <= 3'd0;
      res_tag  <= TAG_NONE;
      res_last <= 1'b0;
    end else begin
      if (state == IDLE && rd_full) grp_len <= rd_len;
      res_tag  <= res_tag_nxt;
      res_last <= res_last_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_boe_feeder.sv
`timescale 1ns/1ps
module tb_boe_feeder;
  localparam int NMAX = boe_pkg::MAX_NUM;
  localparam int MAXC = 4096;
  localparam int MAXG = 2048;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready, boe_rst, len_err;
  logic [2:0] data_num;
  logic [7:0] data_in;
`ifdef BOE_FEEDER_TAG_EN
  logic [1:0] res_tag;
  logic [0:0] res_last;
`endif

  always #5 clk = ~clk;

  boe_feeder dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .boe_rst  (boe_rst),
    .data_num (data_num),
    .data_in  (data_in),
    .len_err  (len_err)
`ifdef BOE_FEEDER_TAG_EN
    ,
    .res_tag  (res_tag),
    .res_last (res_last)
`endif
  );

  // ---------------------------------------------------------------- model
  // Transaction-level view: each closed group g has first issue cycle
  // F_g = max(T_close+2, F_{g-1}+2N_{g-1}+4); its buffer (g%2) is reusable
  // from F_g+N_g. Expected outputs are painted into per-cycle arrays.
  int   cyc;
  bit   chk_en;
  int   n_pass, n_total;
  int   ngrp, cur_len, next_f, err_from;
  logic [7:0] cur [8];
  int   grp_f [MAXG];
  int   grp_n [MAXG];
  int   e_data [MAXC];
  int   e_num  [MAXC];
  int   e_rst  [MAXC];
  int   e_rdy  [MAXC];
  int   o_data [MAXC];
  int   o_num  [MAXC];
  int   o_rst  [MAXC];
  int   o_rdy  [MAXC];
  int   o_err  [MAXC];
`ifdef BOE_FEEDER_TAG_EN
  int   e_tag  [MAXC];
  int   e_last [MAXC];
  int   o_tag  [MAXC];
  int   o_last [MAXC];
`endif

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
  endtask

  task automatic model_clear();
    ngrp = 0; cur_len = 0; next_f = 0; err_from = 1 << 30;
    for (int i = 0; i < MAXC; i++) begin
      e_data[i] = 0; e_num[i] = 0; e_rst[i] = 1; e_rdy[i] = 1;
      o_data[i] = -1; o_num[i] = -1; o_rst[i] = -1; o_rdy[i] = -1; o_err[i] = -1;
`ifdef BOE_FEEDER_TAG_EN
      e_tag[i] = 0; e_last[i] = 0; o_tag[i] = -1; o_last[i] = -1;
`endif
    end
  endtask

  function automatic int model_ready(input int t);
    if (ngrp < 2) return 1;
    return (t >= grp_f[ngrp-2] + grp_n[ngrp-2]) ? 1 : 0;
  endfunction

  task automatic model_accept(input int t, input logic [7:0] d, input bit l);
    int f, n;
    cur[cur_len] = d;
    cur_len++;
    if (l || cur_len == NMAX) begin
      if (!l && err_from > t + 1) err_from = t + 1;
      n = cur_len;
      f = (t + 2 > next_f) ? t + 2 : next_f;
      grp_f[ngrp] = f;
      grp_n[ngrp] = n;
      for (int k = 0; k <= 2*n + 2; k++) e_rst[f+k] = 0;
      e_num[f] = n;
      for (int k = 0; k < n; k++) e_data[f+k] = cur[k];
`ifdef BOE_FEEDER_TAG_EN
      e_tag[f+n+1] = 1;
      e_tag[f+n+2] = 2;
      for (int k = 3; k <= n + 2; k++) e_tag[f+n+k] = 3;
      e_last[f+2*n+2] = 1;
`endif
      next_f = f + 2*n + 4;
      ngrp++;
      cur_len = 0;
    end
  endtask

  // ---------------------------------------------------------------- compare
  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      o_data[cyc] = data_in; o_num[cyc] = data_num; o_rst[cyc] = boe_rst;
      o_rdy[cyc] = in_ready; o_err[cyc] = len_err;
      chk("in_ready", in_ready, e_rdy[cyc]);
      chk("boe_rst", boe_rst, e_rst[cyc]);
      chk("data_num", data_num, e_num[cyc]);
      chk("data_in", data_in, e_data[cyc]);
      chk("len_err", len_err, (cyc >= err_from) ? 1 : 0);
`ifdef BOE_FEEDER_TAG_EN
      o_tag[cyc] = res_tag; o_last[cyc] = res_last;
      chk("res_tag", res_tag, e_tag[cyc]);
      chk("res_last", res_last, e_last[cyc]);
`endif
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic do_reset(input int n);
    chk_en = 0; rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'd0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    cyc = 0;
    chk_en = 1;
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input bit l, output bit acc);
    in_valid = v; in_data = d; in_last = l;
    e_rdy[cyc] = model_ready(cyc);
    acc = v && (e_rdy[cyc] != 0);
    if (acc) model_accept(cyc, d, l);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic settle();
    bit a;
    for (int i = 0; i < 400 && cyc < next_f + 3; i++) drive(0, 8'd0, 0, a);
  endtask

  initial begin
    bit a;
    int target;
    n_pass = 0; n_total = 0; chk_en = 0; cyc = 0;
    model_clear();

    // group {5,3,9}: F=4
    do_reset(2);
    drive(1, 8'd5, 0, a); drive(1, 8'd3, 0, a); drive(1, 8'd9, 1, a);
    settle();
    chk("p1_model_f", grp_f[0], 4);
    chk("p1_rst_pre", o_rst[3], 1);
    chk("p1_num_f", o_num[4], 3);
    chk("p1_d0", o_data[4], 5);
    chk("p1_num_f1", o_num[5], 0);
    chk("p1_d1", o_data[5], 3);
    chk("p1_d2", o_data[6], 9);
    chk("p1_rst_f", o_rst[4], 0);
    chk("p1_rst_f8", o_rst[12], 0);
    chk("p1_rst_f9", o_rst[13], 1);

    // {7} then {1,2}: F=2, F'=8, single boe_rst cycle at 7
    do_reset(2);
    drive(1, 8'd7, 1, a); drive(1, 8'd1, 0, a); drive(1, 8'd2, 1, a);
    settle();
    chk("p2_model_f1", grp_f[1], 8);
    chk("p2_rst6", o_rst[6], 0);
    chk("p2_rst7", o_rst[7], 1);
    chk("p2_rst8", o_rst[8], 0);
    chk("p2_num8", o_num[8], 2);
    chk("p2_d9", o_data[9], 2);

    // 1..7 with no in_last, then 8 with last
    do_reset(2);
    for (int i = 1; i <= 7; i++) drive(1, 8'(i), 0, a);
    drive(1, 8'd8, 1, a);
    settle();
    chk("p3_err5", o_err[5], 0);
    chk("p3_err6", o_err[6], 1);
    chk("p3_num7", o_num[7], 6);
    chk("p3_d12", o_data[12], 6);
    chk("p3_num23", o_num[23], 2);
    chk("p3_d23", o_data[23], 7);
    chk("p3_d24", o_data[24], 8);

    // continuous streaming, groups of 3
    do_reset(2);
    for (int i = 0; i < 40; i++) drive(1, 8'($urandom_range(0, 255)), cur_len == 2, a);
    settle();
    chk("p4_rdy6", o_rdy[6], 0);
    chk("p4_rdy7", o_rdy[7], 1);
    chk("p4_rdy16", o_rdy[16], 0);
    chk("p4_rdy17", o_rdy[17], 1);
    chk("p4_model_f2", grp_f[2], 24);

    // overflow group, 4-byte group, buffered 2-byte group, reset in DRAIN
    do_reset(2);
    for (int i = 0; i < 6; i++) drive(1, 8'(10 + i), 0, a);
    for (int i = 0; i < 4; i++) drive(1, 8'(20 + i), i == 3, a);
    for (int i = 0; i < 20 && ngrp < 3; i++) drive(1, 8'(30 + cur_len), cur_len == 1, a);
    chk("p5_model_f1", grp_f[1], 23);
    while (cyc < grp_f[1] + grp_n[1] + 2) drive(0, 8'd0, 0, a);
    chk("p5_rst_drain", o_rst[28], 0);
    chk("p5_err_set", o_err[28], 1);
    do_reset(1);
    for (int i = 0; i < 40; i++) drive(0, 8'd0, 0, a);
    drive(1, 8'h55, 1, a);
    settle();
    chk("p5_post_rst", o_rst[0], 1);
    chk("p5_post_rdy", o_rdy[0], 1);
    chk("p5_post_err", o_err[0], 0);
    chk("p5_post_num", o_num[42], 1);

`ifdef BOE_FEEDER_TAG_EN
    do_reset(2);
    drive(1, 8'd200, 1, a);
    settle();
    chk("p6_tag3", o_tag[3], 0);
    chk("p6_tag4", o_tag[4], 1);
    chk("p6_tag5", o_tag[5], 2);
    chk("p6_tag6", o_tag[6], 3);
    chk("p6_last6", o_last[6], 1);
    chk("p6_last5", o_last[5], 0);
`endif

    // randomized traffic, lengths 1..7 (7 overflows)
    do_reset(2);
    target = $urandom_range(1, 7);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0)
        repeat ($urandom_range(1, 12)) drive(0, 8'd0, 0, a);
      drive($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
            cur_len + 1 == target, a);
      if (a && cur_len == 0) target = $urandom_range(1, 7);
    end
    settle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
